// File: rtl/nn_pkg.sv
// Shared types and dimensions for the digit classifier datapath.
// The output layer and the argmax stage both size their vectors from here.
package nn_pkg;

   localparam int NUM_CLASSES = 10;
   localparam int LOGIT_W     = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// One argmax step: keeps the current best unless the candidate is strictly larger.
// Because the compare is strict, a tie keeps the earlier (lower) index.
module argmax_cmp #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 4
) (
   input  logic signed [DATA_W-1:0] cand_val,
   input  logic        [IDX_W-1:0]  cand_idx,
   input  logic signed [DATA_W-1:0] best_val,
   input  logic        [IDX_W-1:0]  best_idx,
   output logic signed [DATA_W-1:0] next_val,
   output logic        [IDX_W-1:0]  next_idx
);

   always_comb begin
      next_val = best_val;
      next_idx = best_idx;
      if (cand_val > best_val) begin
         next_val = cand_val;
         next_idx = cand_idx;
      end
   end

endmodule

// File: rtl/output_argmax.sv
// Sequential signed argmax over the output-layer logit vector, one logit per cycle,
// with a valid/ready result port and a saturating count of vectors dropped while busy.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a vector; valid_in is captured immediately
// SCAN  | comparing logit[scan_idx] against the running best
// HOLD  | result presented, waiting for valid_out && ready_in
module output_argmax #(
   parameter int NUM_CLASSES = nn_pkg::NUM_CLASSES,
   parameter int DATA_W      = nn_pkg::LOGIT_W,
   parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [DATA_W-1:0] logits_in [NUM_CLASSES],
   input  logic                     valid_in,
   input  logic                     ready_in,
   output logic        [IDX_W-1:0]  class_out,
   output logic signed [DATA_W-1:0] max_logit,
   output logic                     valid_out,
   output logic                     busy,
   output logic                     overrun,
   output logic        [7:0]        drop_count
);

   import nn_pkg::*;

   argmax_state_t state_q, state_d;

   logic signed [DATA_W-1:0] logit_buf [NUM_CLASSES];
   logic        [IDX_W-1:0]  scan_idx;
   logic        [IDX_W-1:0]  best_idx;
   logic signed [DATA_W-1:0] best_val;
   logic signed [DATA_W-1:0] next_val;
   logic        [IDX_W-1:0]  next_idx;

   logic handshake;
   logic accept;
   logic drop;
   logic last;

   // valid_out is high for the whole of HOLD, so the handshake reduces to ready_in there.
   assign handshake = (state_q == HOLD) && ready_in;
   assign accept    = valid_in && ((state_q == IDLE) || handshake);
   assign drop      = valid_in && !accept;
   assign last      = (scan_idx == IDX_W'(NUM_CLASSES - 1));
   assign busy      = (state_q != IDLE);

   argmax_cmp #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_cmp (
      .cand_val (logit_buf[scan_idx]),
      .cand_idx (scan_idx),
      .best_val (best_val),
      .best_idx (best_idx),
      .next_val (next_val),
      .next_idx (next_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = SCAN;
         SCAN:    if (last)   state_d = HOLD;
         HOLD:    if (handshake) state_d = accept ? SCAN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Buffer contents are don't-care after reset; they are only read in SCAN.
   always_ff @(posedge clk) begin
      if (accept) logit_buf <= logits_in;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_idx   <= '0;
         best_idx   <= '0;
         best_val   <= '0;
         class_out  <= '0;
         max_logit  <= '0;
         valid_out  <= 1'b0;
         overrun    <= 1'b0;
         drop_count <= '0;
      end else begin
         overrun <= drop;
         if (drop && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;

         if (handshake) valid_out <= 1'b0;

         if (state_q == SCAN) begin
            best_val <= next_val;
            best_idx <= next_idx;
            scan_idx <= scan_idx + IDX_W'(1);
            if (last) begin
               class_out <= next_idx;
               max_logit <= next_val;
               valid_out <= 1'b1;
            end
         end

         // Element 0 seeds the running best, so scanning starts at index 1.
         if (accept) begin
            best_val <= logits_in[0];
            best_idx <= '0;
            scan_idx <= IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_output_argmax.sv
// Directed and randomized checks of output_argmax against a max-then-first-match
// reference model of the argmax and a saturating drop counter model.
module tb_output_argmax;

   localparam int N  = 10;
   localparam int W  = 16;
   localparam int IW = 4;

   typedef logic signed [W-1:0] vec_t [N];

   logic                clk = 1'b0;
   logic                rst;
   logic signed [W-1:0] logits_in [N];
   logic                valid_in;
   logic                ready_in;
   logic [IW-1:0]       class_out;
   logic signed [W-1:0] max_logit;
   logic                valid_out;
   logic                busy;
   logic                overrun;
   logic [7:0]          drop_count;

   int checks = 0;
   int errors = 0;
   int model_drops = 0;

   output_argmax #(.NUM_CLASSES(N), .DATA_W(W), .IDX_W(IW)) dut (
      .clk        (clk),
      .rst        (rst),
      .logits_in  (logits_in),
      .valid_in   (valid_in),
      .ready_in   (ready_in),
      .class_out  (class_out),
      .max_logit  (max_logit),
      .valid_out  (valid_out),
      .busy       (busy),
      .overrun    (overrun),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reference: find the maximum value, then the first index holding it.
   function automatic longint ref_val(input vec_t v);
      longint m = longint'(v[0]);
      foreach (v[i]) if (longint'(v[i]) > m) m = longint'(v[i]);
      return m;
   endfunction

   function automatic longint ref_idx(input vec_t v);
      longint m = ref_val(v);
      for (int i = 0; i < N; i++) if (longint'(v[i]) == m) return longint'(i);
      return -1;
   endfunction

   function automatic void note_drop();
      if (model_drops < 255) model_drops++;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input vec_t v);
      logits_in = v;
      valid_in  = 1'b1;
      tick();
      valid_in  = 1'b0;
   endtask

   // Called just after the capture edge E0; returns after valid_out is seen.
   task automatic wait_result(input string tag, input vec_t v);
      int lat = 0;
      do begin
         tick();
         lat++;
      end while (!valid_out && lat < 40);
      chk({tag, " latency"}, lat, N - 1);
      chk({tag, " class"}, longint'(class_out), ref_idx(v));
      chk({tag, " max"}, longint'(max_logit), ref_val(v));
   endtask

   task automatic complete(input string tag);
      ready_in = 1'b1;
      tick();
      ready_in = 1'b0;
      chk({tag, " valid_out after handshake"}, longint'(valid_out), 0);
      chk({tag, " busy after handshake"}, longint'(busy), 0);
   endtask

   function automatic vec_t rand_vec(input bit narrow);
      vec_t v;
      foreach (v[i]) v[i] = narrow ? W'(int'($urandom_range(0, 6)) - 3) : W'($urandom);
      return v;
   endfunction

   initial begin
      vec_t v, v2;
      longint hold_cls, hold_max;

      rst      = 1'b1;
      valid_in = 1'b0;
      ready_in = 1'b0;
      foreach (logits_in[i]) logits_in[i] = '0;
      #12;
      chk("reset class_out", longint'(class_out), 0);
      chk("reset max_logit", longint'(max_logit), 0);
      chk("reset valid_out", longint'(valid_out), 0);
      chk("reset busy", longint'(busy), 0);
      chk("reset overrun", longint'(overrun), 0);
      chk("reset drop_count", longint'(drop_count), 0);
      tick();
      rst = 1'b0;
      tick();

      // Tie at 200 between indices 3 and 5; lower index wins.
      v = '{16'sd10, -16'sd5, 16'sd3, 16'sd200, 16'sd7, 16'sd200, 16'sd0, -16'sd1, 16'sd50, 16'sd199};
      chk("tie model", ref_idx(v), 3);
      ready_in = 1'b1;
      send(v);
      chk("tie busy in scan", longint'(busy), 1);
      wait_result("tie", v);
      tick();
      ready_in = 1'b0;
      chk("tie valid_out cleared", longint'(valid_out), 0);
      chk("tie busy cleared", longint'(busy), 0);

      v = '{-16'sd300, -16'sd2, -16'sd50, -16'sd7, -16'sd1000, -16'sd3, -16'sd2, -16'sd9, 16'sh8000, -16'sd100};
      send(v);
      wait_result("negative", v);
      chk("negative class const", longint'(class_out), 1);
      chk("negative max const", longint'(max_logit), -2);
      complete("negative");

      foreach (v[i]) v[i] = 16'sh8000;
      send(v);
      wait_result("all min", v);
      chk("all min max const", longint'(max_logit), -32768);
      complete("all min");

      foreach (v[i]) v[i] = 16'sh7FFF;
      send(v);
      wait_result("all max", v);
      chk("all max class const", longint'(class_out), 0);
      complete("all max");

      // Backpressure with a single drop mid-HOLD.
      v = rand_vec(1'b0);
      send(v);
      wait_result("bp", v);
      hold_cls = ref_idx(v);
      hold_max = ref_val(v);
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin
            logits_in = rand_vec(1'b0);
            valid_in  = 1'b1;
            tick();
            valid_in  = 1'b0;
            note_drop();
            chk("bp overrun pulse", longint'(overrun), 1);
            chk("bp drop_count", longint'(drop_count), longint'(model_drops));
         end else begin
            tick();
            chk("bp overrun idle", longint'(overrun), 0);
         end
         chk("bp valid_out stable", longint'(valid_out), 1);
         chk("bp class stable", longint'(class_out), hold_cls);
         chk("bp max stable", longint'(max_logit), hold_max);
      end

      // Saturation: 300 consecutive drops while held.
      valid_in = 1'b1;
      for (int k = 0; k < 300; k++) begin
         logits_in = rand_vec(1'b0);
         tick();
         note_drop();
      end
      valid_in = 1'b0;
      chk("sat drop_count", longint'(drop_count), longint'(model_drops));
      chk("sat drop_count const", longint'(drop_count), 255);
      chk("sat class unchanged", longint'(class_out), hold_cls);
      chk("sat max unchanged", longint'(max_logit), hold_max);
      complete("sat");

      // Back-to-back: new vector arrives on the handshake edge.
      v = rand_vec(1'b0);
      send(v);
      wait_result("b2b first", v);
      tick();
      foreach (v2[i]) v2[i] = W'(int'($urandom_range(0, 1040)) - 1000);
      v2[N-1] = 16'sd42;
      logits_in = v2;
      valid_in  = 1'b1;
      ready_in  = 1'b1;
      tick();
      valid_in  = 1'b0;
      ready_in  = 1'b0;
      chk("b2b valid_out dropped", longint'(valid_out), 0);
      chk("b2b busy", longint'(busy), 1);
      chk("b2b no overrun", longint'(overrun), 0);
      wait_result("b2b second", v2);
      chk("b2b class const", longint'(class_out), 9);
      chk("b2b max const", longint'(max_logit), 42);
      chk("b2b drop_count", longint'(drop_count), longint'(model_drops));
      complete("b2b");

      // Reset mid-scan.
      send(rand_vec(1'b0));
      for (int k = 0; k < 4; k++) tick();
      rst = 1'b1;
      model_drops = 0;
      #1;
      chk("rst class_out", longint'(class_out), 0);
      chk("rst max_logit", longint'(max_logit), 0);
      chk("rst valid_out", longint'(valid_out), 0);
      chk("rst busy", longint'(busy), 0);
      chk("rst overrun", longint'(overrun), 0);
      chk("rst drop_count", longint'(drop_count), longint'(model_drops));
      tick();
      rst = 1'b0;
      tick();
      foreach (v[i]) v[i] = W'(int'($urandom_range(0, 500)) - 250);
      v[5] = 16'sd900;
      send(v);
      wait_result("post rst", v);
      chk("post rst class const", longint'(class_out), 5);
      complete("post rst");

      // Randomized vectors, half with narrow ranges to force ties.
      for (int t = 0; t < 24; t++) begin
         v = rand_vec(t[0]);
         send(v);
         wait_result("rand", v);
         for (int d = 0; d < int'($urandom_range(0, 3)); d++) tick();
         chk("rand held class", longint'(class_out), ref_idx(v));
         complete("rand");
      end
      chk("final drop_count", longint'(drop_count), longint'(model_drops));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/output_argmax.md
# output_argmax

Consumes the 10-logit result vector from the fully connected output layer and reduces it to a predicted digit class by a sequential signed argmax. Sits directly after the output layer: captures the vector on the layer's one-cycle `valid_out` pulse, scans one logit per cycle, then presents the class index and winning logit to the downstream consumer under a valid/ready handshake. The upstream layer has no backpressure input, so this block detects and counts vectors it cannot accept.

## Interface
- `NUM_CLASSES`, default 10, number of logits per vector (≥2)
- `DATA_W`, default 16, logit width, signed two's complement
- `IDX_W`, default 4, class index width, $clog2(NUM_CLASSES)
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `logits_in`  in  signed [DATA_W-1:0] x [0:NUM_CLASSES-1]  logit vector, valid only in the `valid_in` cycle
- `valid_in`  in  1  one-cycle pulse, vector present
- `ready_in`  in  1  downstream can take the result
- `class_out`  out  [IDX_W-1:0]  predicted class index
- `max_logit`  out  signed [DATA_W-1:0]  value of the winning logit
- `valid_out`  out  1  result valid, held until accepted
- `busy`  out  1  high when the FSM is not in IDLE
- `overrun`  out  1  one-cycle pulse, input vector dropped
- `drop_count`  out  [7:0]  dropped vectors, saturates at 255

## Operation
- FSM states:
  - IDLE:
    - On `valid_in`, capture all logits into the buffer, set best_idx=0, best_val=logits_in[0], scan_idx=1, go to SCAN.
  - SCAN:
    - Each cycle, if buf[scan_idx] > best_val (strict signed compare), set best_idx=scan_idx and best_val=buf[scan_idx].
    - Increment scan_idx.
    - After index NUM_CLASSES-1 is processed, load `class_out`/`max_logit`, set `valid_out`=1, go to HOLD.
  - HOLD:
    - `valid_out`, `class_out` and `max_logit` stay stable until `valid_out && ready_in` at an edge.
    - After that handshake, clear `valid_out` and go to IDLE.
- Ties: the lowest index wins, because the compare is strict.
- Arithmetic: signed compare at full DATA_W; no saturation or rescale. `max_logit` is bit-exact to the input.
- Drop rule:
  - `valid_in` in SCAN, or in HOLD without a completing handshake in the same cycle, is ignored.
  - `overrun` pulses for 1 cycle and `drop_count` increments unless it is at 255.
  - The in-flight result is unaffected.
- Back-to-back: `valid_in` in the same cycle as a HOLD handshake is accepted. The block captures the new vector and goes straight to SCAN, with no drop. `valid_out` deasserts on that edge.
- `busy` is decoded from the state register, so it has no combinational path from inputs.

## Timing
- Reset values, asynchronously on `rst`:
  - state=IDLE
  - `class_out`=0, `max_logit`=0
  - `valid_out`=0, `busy`=0, `overrun`=0
  - `drop_count`=0
  - buffer contents don't-care
- Reset mid-SCAN or mid-HOLD abandons the result with no output pulse. The first `valid_in` after `rst` deasserts is processed normally.
- Latency: `valid_in` sampled at edge E0 → `valid_out` high after edge E(NUM_CLASSES-1), which is E9 at the defaults.
- Throughput: one vector per NUM_CLASSES cycles when `ready_in` is held high.
- `busy` rises after E0 and falls after the handshake edge, unless a back-to-back capture occurs.
- `overrun` is registered and asserts the cycle after the dropped `valid_in`.

## Structure
- Shared package `nn_pkg`:
  - state enum `argmax_state_t` {IDLE, SCAN, HOLD}
  - localparams `NUM_CLASSES`=10 and `LOGIT_W`=16, shared with the output layer
- Sub-module `argmax_cmp`: combinational stage. Takes candidate value/index and current best value/index; returns the next best value/index using the strict signed greater-than rule.
- Top level holds the FSM, capture buffer, scan counter and drop counter.

## Test plan
- Tie handling: logits [10,-5,3,200,7,200,0,-1,50,199], `ready_in`=1 → `valid_out` after E9, `class_out`=3, `max_logit`=200, back to IDLE next edge.
- Negative values: logits all negative [-300,-2,-50,-7,-1000,-3,-2,-9,-32768,-100] → `class_out`=1, `max_logit`=-2.
- All-equal extreme: all logits 16'sh8000 → `class_out`=0, `max_logit`=-32768. All logits 16'sh7FFF → `class_out`=0, `max_logit`=32767.
- Backpressure and overrun:
  - Hold `ready_in`=0 for 5 cycles after `valid_out`; outputs stay stable.
  - A `valid_in` pulse mid-HOLD gives one `overrun` pulse and `drop_count`=1; result unchanged.
  - 300 dropped pulses → `drop_count`=255.
- Back-to-back: second vector (winner index 9, value 42) with `valid_in` on the handshake edge of the first → no `overrun`. Second result appears 9 edges later: `class_out`=9, `max_logit`=42.
- Reset mid-scan: `rst` pulsed 4 cycles after `valid_in` → all outputs 0 and `busy`=0 immediately. Then a fresh vector with max at index 5 → `class_out`=5, latency 9 edges.
